// File: rtl/mux_sel_arb_rc.sv
// Two-requester round-robin arbiter that drives the SEL input of the RC-modelled 2:1 mux.
// A break-before-make SW state makes sure SEL never changes while either grant is high.
module mux_sel_arb_rc #(
    parameter int WP       = 20,
    parameter int WN       = 10,
    parameter int HOLD_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic sel,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam int HW      = (HOLD_MAX > 0) ? (($clog2(HOLD_MAX + 1) > 0) ? $clog2(HOLD_MAX + 1) : 1) : 1;
    localparam int HTRIG_I = (HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0;
    localparam logic [HW-1:0] HLIM  = HW'(HOLD_MAX);
    localparam logic [HW-1:0] HTRIG = HW'(HTRIG_I);
    localparam logic [HW-1:0] HONE  = HW'(1);
    localparam logic          HOLD_EN = (HOLD_MAX > 0) ? 1'b1 : 1'b0;

    // Driver sizing only shapes the analog edges of the switch-level view.
    if ((WP < 1) || (WN < 1)) begin : g_bad_driver_size
        $error("mux_sel_arb_rc: WP and WN must be positive");
    end

    logic [1:0]    state_r, state_nxt_s;
    logic          sel_r, sel_nxt_s;
    logic          last_r, last_nxt_s;
    logic          tgt_r, tgt_nxt_s;
    logic [HW-1:0] hcnt_r, hcnt_nxt_s;
    logic          gnt0_r, gnt1_r;
    logic          pick_s;
    logic          own_req_s;
    logic          oth_req_s;
    logic          holder_s;

    // Next-state, SEL, LAST and hold-counter decisions.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        last_nxt_s  = last_r;
        tgt_nxt_s   = tgt_r;
        hcnt_nxt_s  = hcnt_r;
        holder_s    = (state_r == ST_G1) ? 1'b1 : 1'b0;
        own_req_s   = holder_s ? req1 : req0;
        oth_req_s   = holder_s ? req0 : req1;
        if (req0 && req1) begin
            pick_s = ~last_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (pick_s == sel_r) begin
                        state_nxt_s = pick_s ? ST_G1 : ST_G0;
                        hcnt_nxt_s  = '0;
                    end else begin
                        state_nxt_s = ST_SW;
                        sel_nxt_s   = pick_s;
                        tgt_nxt_s   = pick_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SW: begin
                if (tgt_r ? req1 : req0) begin
                    state_nxt_s = tgt_r ? ST_G1 : ST_G0;
                    hcnt_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_G0, ST_G1: begin
                if (!own_req_s) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = holder_s;
                end else if (HOLD_EN && oth_req_s && (hcnt_r >= HTRIG)) begin
                    // >= rather than == so a counter that saturated while
                    // the other side was quiet still hands over promptly.
                    state_nxt_s = ST_SW;
                    sel_nxt_s   = ~holder_s;
                    tgt_nxt_s   = ~holder_s;
                    last_nxt_s  = holder_s;
                end else if (hcnt_r != HLIM) begin
                    hcnt_nxt_s = hcnt_r + HONE;
                end else begin
                    hcnt_nxt_s = hcnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset pulls every output low at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= 1'b0;
            last_r  <= 1'b1;
            tgt_r   <= 1'b0;
            hcnt_r  <= '0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            last_r  <= last_nxt_s;
            tgt_r   <= tgt_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
            gnt0_r  <= (state_nxt_s == ST_G0) ? 1'b1 : 1'b0;
            gnt1_r  <= (state_nxt_s == ST_G1) ? 1'b1 : 1'b0;
        end
    end

    assign sel  = sel_r;
    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;

endmodule

// File: tb/tb_mux_sel_arb_rc.sv
// Directed bench for mux_sel_arb_rc: one instance with HOLD_MAX=4, one with HOLD_MAX=0.
module tb_mux_sel_arb_rc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic req0_b = 1'b1, req1_b = 1'b1;
    logic sel, gnt0, gnt1;
    logic sel_b, gnt0_b, gnt1_b;
    int   passes = 0;
    int   total = 0;

    mux_sel_arb_rc #(.WP(20), .WN(10), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .sel(sel), .gnt0(gnt0), .gnt1(gnt1)
    );

    mux_sel_arb_rc #(.WP(40), .WN(20), .HOLD_MAX(0)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
        .sel(sel_b), .gnt0(gnt0_b), .gnt1(gnt1_b)
    );

    always #5 clk = ~clk;

    // Compare {sel,gnt0,gnt1}
    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed={sel,gnt0,gnt1}=%b expected=%b", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] fair_exp [11];

    initial begin
        fair_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                     3'b101, 3'b101, 3'b101, 3'b101, 3'b000, 3'b010};

        // Reset state
        step();
        chk("reset", {sel, gnt0, gnt1}, 3'b000);
        chk("reset_b", {sel_b, gnt0_b, gnt1_b}, 3'b000);

        // Release with both requesting: REQ0 wins first tie, then fairness
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk($sformatf("fair_%0d", i + 1), {sel, gnt0, gnt1}, fair_exp[i]);
            chk($sformatf("hold0_%0d", i + 1), {sel_b, gnt0_b, gnt1_b}, 3'b010);
        end

        // Release: both drop, holder G0 -> IDLE
        req0 = 1'b0; req1 = 1'b0;
        step(); chk("release", {sel, gnt0, gnt1}, 3'b000);

        // Single requester REQ1 for three edges from SEL=0
        req1 = 1'b1;
        step(); chk("single_sw", {sel, gnt0, gnt1}, 3'b100);
        step(); chk("single_g1a", {sel, gnt0, gnt1}, 3'b101);
        step(); chk("single_g1b", {sel, gnt0, gnt1}, 3'b101);
        req1 = 1'b0;
        step(); chk("single_rel", {sel, gnt0, gnt1}, 3'b100);

        // REQ0 alone from SEL=1 goes through SW
        req0 = 1'b1;
        step(); chk("r0_sw", {sel, gnt0, gnt1}, 3'b000);
        step(); chk("r0_g0", {sel, gnt0, gnt1}, 3'b010);

        // Holder drops while other rises at the same edge: IDLE first
        req0 = 1'b0; req1 = 1'b1;
        step(); chk("swap_idle", {sel, gnt0, gnt1}, 3'b000);
        step(); chk("swap_sw", {sel, gnt0, gnt1}, 3'b100);

        // Abort during SW: REQ1 drops, no GNT1 pulse, SEL stays 1
        req1 = 1'b0;
        step(); chk("abort", {sel, gnt0, gnt1}, 3'b100);
        step(); chk("abort_hold", {sel, gnt0, gnt1}, 3'b100);

        // IDLE with SEL=1 and REQ1 -> direct grant
        req1 = 1'b1;
        step(); chk("direct_g1", {sel, gnt0, gnt1}, 3'b101);

        // Asynchronous reset mid-grant, no clock edge in between
        #2 rst = 1'b1;
        #1 chk("async_rst", {sel, gnt0, gnt1}, 3'b000);
        chk("async_rst_b", {sel_b, gnt0_b, gnt1_b}, 3'b000);
        #1 rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        step(); chk("post_rst_tie", {sel, gnt0, gnt1}, 3'b010);
        step(); chk("post_rst_hold", {sel, gnt0, gnt1}, 3'b010);

        // HOLD_MAX=0: GNT0 never released, SEL never moves
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("unlim_%0d", i), {sel_b, gnt0_b, gnt1_b}, 3'b010);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
